// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_stage
// Brief    : PC-driven instruction fetch with req/ack memory port, 2-entry
//            fetch buffer toward decode, and a pc_advance strobe to step the PC.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    input  logic              flush,
    output logic              pc_advance,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              ifid_valid,
    input  logic              ifid_ready,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_pc_plus4,
    output logic              misalign_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state_q,    state_d;
    logic              req_q,      req_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic              adv_q,      adv_d;
    logic              mis_q,      mis_d;
    logic [1:0]        count_q,    count_d;
    logic              rd_ptr_q,   rd_ptr_d;
    logic              wr_ptr_q,   wr_ptr_d;
    logic [DATA_W-1:0] buf_instr_q [2];
    logic [DATA_W-1:0] buf_instr_d [2];
    logic [ADDR_W-1:0] buf_pc_q    [2];
    logic [ADDR_W-1:0] buf_pc_d    [2];

    logic w_push;
    logic w_pop;
    logic w_aligned;

    assign w_aligned = (pc[1:0] == 2'b00);
    assign w_pop     = (count_q != 2'd0) && ifid_ready;

    // Fetch sequencer. While pc_advance is high the PC has not yet stepped,
    // so the stale pc is not re-issued that cycle.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        adv_d   = 1'b0;
        mis_d   = mis_q;
        w_push  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pc_valid && !w_aligned) begin
                    mis_d = 1'b1;
                end
                if (pc_valid && w_aligned && !flush && !adv_q && (count_q < 2'd2)) begin
                    req_d   = 1'b1;
                    addr_d  = pc;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                    if (!flush) begin
                        w_push = 1'b1;
                        adv_d  = 1'b1;
                    end
                end else if (flush) begin
                    // Request must stay up until the memory acknowledges it.
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Fetch buffer; flush overrides both push and pop.
    always_comb begin
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (w_push) begin
                buf_instr_d[wr_ptr_q] = imem_rdata;
                buf_pc_d[wr_ptr_q]    = addr_q;
                wr_ptr_d              = ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            req_q          <= 1'b0;
            addr_q         <= '0;
            adv_q          <= 1'b0;
            mis_q          <= 1'b0;
            count_q        <= 2'd0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            buf_instr_q[0] <= '0;
            buf_instr_q[1] <= '0;
            buf_pc_q[0]    <= '0;
            buf_pc_q[1]    <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            adv_q       <= adv_d;
            mis_q       <= mis_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    assign pc_advance    = adv_q;
    assign imem_req      = req_q;
    assign imem_addr     = addr_q;
    assign misalign_err  = mis_q;
    assign ifid_valid    = (count_q != 2'd0);
    // Head fields read zero when the buffer is empty.
    assign ifid_instr    = ifid_valid ? buf_instr_q[rd_ptr_q] : '0;
    assign ifid_pc       = ifid_valid ? buf_pc_q[rd_ptr_q] : '0;
    assign ifid_pc_plus4 = ifid_valid ? (buf_pc_q[rd_ptr_q] + ADDR_W'(4)) : '0;

endmodule
`default_nettype wire
